// File: rtl/fpu_result_buffer.sv
// Purpose: credit-gated result FIFO behind the fixed-latency, non-stallable FPU pipeline.
// Latency: 1 cycle from res_valid to out_valid (first-word-fall-through, no bypass).
// Backpressure: out_ready stalls the head; credits (issue_ready) stop new launches so results are never lost.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   issue_valid/rdy - FPU launch request / credit available (registered state only)
//   res_valid/data  - result from the FPU final stage (cannot be stalled)
//   out_valid/data  - buffer head, popped when out_ready is high
//   out_ready       - downstream accepts the head
//   count           - results currently stored
//   in_flight       - ops launched and not yet returned
//   overflow        - sticky protocol-error flag (stray or overflowing result)

`timescale 1ns/1ps

module fpu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         res_valid,
  input  logic [WIDTH-1:0]             res_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   in_flight,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    in_flight_q;
  logic             overflow_q;

  // One extra bit so count + in_flight cannot wrap before the compare.
  logic [CW:0]      occupancy;

  logic issue;
  logic pop;
  logic stray;
  logic ret;
  logic full_drop;
  logic accept;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    next_ptr = (ptr == AW'(DEPTH-1)) ? '0 : ptr + AW'(1);
  endfunction

  // Credits are granted from registered state only: a pop this cycle frees
  // its slot for launches starting next cycle.
  assign occupancy   = {1'b0, count_q} + {1'b0, in_flight_q};
  assign issue_ready = occupancy < (CW+1)'(DEPTH);

  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr];

  assign issue = issue_valid & issue_ready;
  assign pop   = out_valid & out_ready;

  // A result with nothing outstanding is stray: dropped and flagged, and it
  // does not cancel a launch happening in the same cycle.
  assign stray = res_valid & (in_flight_q == '0);
  assign ret   = res_valid & ~stray;

  // At full, a result can still land if the head leaves in the same cycle.
  assign full_drop = ret & (count_q == CW'(DEPTH)) & ~pop;
  assign accept    = ret & ~full_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end

      if (accept && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !accept) begin
        count_q <= count_q - CW'(1);
      end

      // A returned-but-dropped result (full_drop) still retires its credit.
      if (issue && !ret) begin
        in_flight_q <= in_flight_q + CW'(1);
      end else if (ret && !issue) begin
        in_flight_q <= in_flight_q - CW'(1);
      end

      if (stray || full_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: nothing is read until count is non-zero.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= res_data;
    end
  end

  assign count     = count_q;
  assign in_flight = in_flight_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed bench for fpu_result_buffer at DEPTH=4 with a small FPU pipeline model.
// The model presents a launched op's result two edges after its issue edge
// (three cycles counting the issue cycle), which a 4-entry buffer sustains at 1 op/cycle.

`timescale 1ns/1ps

module tb_fpu_result_buffer;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         issue_valid;
  logic         issue_ready;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [2:0]   count;
  logic [2:0]   in_flight;
  logic         overflow;

  logic [W-1:0] issue_dat;
  logic         err_vld;
  logic [W-1:0] err_dat;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] got_q [$];

  always #5 clk = ~clk;

  fpu_result_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .in_flight   (in_flight),
    .overflow    (overflow)
  );

  // FPU model: two pipeline registers behind the launch point.
  logic         pv0 = 1'b0;
  logic         pv1 = 1'b0;
  logic [W-1:0] pd0 = '0;
  logic [W-1:0] pd1 = '0;

  always @(posedge clk) begin
    pv0 <= issue_valid & issue_ready;
    pd0 <= issue_dat;
    pv1 <= pv0;
    pd1 <= pd0;
  end

  assign res_valid = pv1 | err_vld;
  assign res_data  = err_vld ? err_dat : pd1;

  // Record every head word that will be popped at the coming edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after each rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      nxt();
      if (count == 3'd0 && in_flight == 3'd0) done = 1'b1;
    end
    chk({tag, "_idle"}, done, 1);
  endtask

  initial begin
    int acc;
    int sent;
    int occ;
    logic found55;

    issue_valid = 1'b0;
    issue_dat   = '0;
    out_ready   = 1'b0;
    err_vld     = 1'b0;
    err_dat     = '0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_overflow", overflow, 0);
    nxt();
    rst = 1'b1;

    // Fill: 6 back-to-back requests, only 4 credits
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      nxt();
      issue_valid = 1'b1;
      issue_dat   = 32'hA + k;
      chk("fill_issue_ready", issue_ready, (k < 4) ? 1 : 0);
      if (issue_ready) acc++;
    end
    nxt();
    issue_valid = 1'b0;
    repeat (4) nxt();
    chk("fill_accepted", acc, 4);
    chk("fill_count", count, 4);
    chk("fill_in_flight", in_flight, 0);
    chk("fill_overflow", overflow, 0);
    chk("fill_issue_ready_low", issue_ready, 0);
    chk("fill_head", out_data, 32'hA);

    // Drain
    got_q.delete();
    out_ready = 1'b1;
    chk("drain_rdy_same_cycle", issue_ready, 0);
    nxt();
    chk("drain_rdy_after_pop", issue_ready, 1);
    chk("drain_count_after_pop", count, 3);
    repeat (4) nxt();
    out_ready = 1'b0;
    chk("drain_n", got_q.size(), 4);
    for (int i = 0; i < got_q.size(); i++) chk("drain_data", got_q[i], 32'hA + i);
    chk("drain_empty", out_valid, 0);

    // Asynchronous reset mid-operation with 3 stored results
    for (int k = 0; k < 3; k++) begin
      nxt();
      issue_valid = 1'b1;
      issue_dat   = 32'h1 + k;
    end
    nxt();
    issue_valid = 1'b0;
    repeat (4) nxt();
    chk("mid_pre_count", count, 3);
    #2 rst = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_issue_ready", issue_ready, 1);
    chk("mid_count", count, 0);
    chk("mid_in_flight", in_flight, 0);
    chk("mid_overflow", overflow, 0);
    nxt();
    nxt();
    rst = 1'b1;

    // Streaming: 20 consecutive issues, out_ready held high
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nxt();
      issue_valid = 1'b1;
      issue_dat   = i;
      chk("stream_issue_ready", issue_ready, 1);
    end
    nxt();
    issue_valid = 1'b0;
    wait_idle("stream");
    chk("stream_n", got_q.size(), 20);
    for (int i = 0; i < got_q.size(); i++) chk("stream_data", got_q[i], i);

    // Backpressure: out_ready toggles, issue whenever allowed
    got_q.delete();
    sent = 0;
    for (int c = 0; c < 40; c++) begin
      nxt();
      out_ready   = (c % 2 == 0);
      issue_valid = 1'b1;
      issue_dat   = 32'h100 + sent;
      if (issue_ready) sent++;
      occ = count + in_flight;
      chk("bp_occupancy", (occ <= D), 1);
    end
    nxt();
    issue_valid = 1'b0;
    out_ready   = 1'b1;
    wait_idle("bp");
    chk("bp_n", got_q.size(), sent);
    for (int i = 0; i < got_q.size(); i++) chk("bp_data", got_q[i], 32'h100 + i);
    chk("bp_overflow", overflow, 0);

    // Stray result with one word stored
    out_ready = 1'b0;
    nxt();
    issue_valid = 1'b1;
    issue_dat   = 32'h77;
    nxt();
    issue_valid = 1'b0;
    repeat (4) nxt();
    chk("err_pre_count", count, 1);
    err_vld = 1'b1;
    err_dat = 32'h55;
    nxt();
    err_vld = 1'b0;
    chk("err_overflow_set", overflow, 1);
    chk("err_count", count, 1);
    chk("err_head", out_data, 32'h77);
    repeat (3) nxt();
    chk("err_overflow_sticky", overflow, 1);
    got_q.delete();
    out_ready = 1'b1;
    wait_idle("err");
    found55 = 1'b0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] == 32'h55) found55 = 1'b1;
    chk("err_no_stray_out", found55, 0);
    chk("err_n", got_q.size(), 1);
    chk("err_overflow_end", overflow, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_result_buffer.md
# fpu_result_buffer

Output-side companion to the pipelined FPU: it absorbs results emerging from the fixed-latency, non-stallable pipeline into a FIFO. It presents them to downstream logic over a valid/ready handshake. It also issues credits back to the FPU input, so operations are launched only when a buffer slot is guaranteed for their result. Sits between the FPU final stage and any consumer that can apply backpressure.

## Interface
- WIDTH, 32, result word width (bits).
- DEPTH, 8, buffer entries; power of two, >= 2.
- CW (localparam), $clog2(DEPTH+1), counter width.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset; one clock domain only.
- issue_valid  in  1  upstream launches one op into the FPU this cycle.
- issue_ready  out  1  a credit is available; an op may be launched.
- res_valid  in  1  FPU final stage presents a result.
- res_data  in  WIDTH  result word.
- out_valid  out  1  buffer head is valid.
- out_data  out  WIDTH  buffer head word.
- out_ready  in  1  downstream accepts the head.
- count  out  CW  results currently stored.
- in_flight  out  CW  ops issued and not yet returned.
- overflow  out  1  sticky protocol-error flag.

## Operation
- Events per cycle:
  - issue = issue_valid & issue_ready.
  - push = res_valid.
  - pop = out_valid & out_ready.
- in_flight update:
  - +1 on issue only.
  - -1 on push only.
  - Unchanged when both occur or neither occurs.
  - Never decremented below 0.
- count update:
  - +1 on accepted push only.
  - -1 on pop only.
  - Unchanged when both occur.
- issue_ready = (count + in_flight) < DEPTH, computed from registered state only. A pop in the current cycle does not raise issue_ready in that same cycle.
- issue_valid while issue_ready=0 is ignored: no counter change and no error.
- FIFO behaviour:
  - Circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits; pointers wrap DEPTH-1 -> 0.
  - First-word-fall-through: out_data = mem[rd_ptr]; out_valid = (count != 0).
  - No push-to-output bypass.
- Push with count == DEPTH and no pop in the same cycle:
  - Word dropped, pointers unchanged, overflow set.
  - A push and pop in the same cycle at full both proceed.
- Push with in_flight == 0 (stray result):
  - Word dropped, overflow set.
  - in_flight stays 0.
- overflow clears only on reset.
- Ordering: results leave in arrival order; no reordering and no data modification.

## Timing
- Reset (rst=0, asynchronous, effective immediately without a clock edge):
  - out_valid=0, issue_ready=1, count=0, in_flight=0, overflow=0, pointers=0.
  - out_data is don't-care.
- Release of rst is synchronous to the next clk edge.
- Reset mid-operation discards all stored and in-flight bookkeeping. Results arriving afterwards count as stray and set overflow.
- push at edge t -> out_valid=1 after edge t (1-cycle latency into an empty buffer).
- pop at edge t -> next entry presented after edge t. issue_ready may rise after edge t.
- issue at edge t -> in_flight increments after edge t.
- Slot occupancy per op is from the issue edge+1 through the pop edge. With FPU latency L and out_ready held at 1, sustained 1 op/cycle requires DEPTH >= L+1.

## Test plan
- Reset check: assert rst=0 mid-cycle with count=3 -> immediately out_valid=0, issue_ready=1, count=0, in_flight=0, overflow=0.
- Fill (DEPTH=4, FPU model latency 3, out_ready=0):
  - Stimulus: issue 6 back-to-back requests.
  - Required: exactly 4 accepted; issue_ready=0 after the 4th issue.
  - Results 0xA, 0xB, 0xC, 0xD are stored; count=4, in_flight=0, overflow=0.
- Drain: from the full state, set out_ready=1 -> out_data = 0xA, 0xB, 0xC, 0xD on 4 consecutive cycles; issue_ready=1 one cycle after the first pop.
- Streaming (DEPTH=4, latency 3, out_ready=1):
  - Stimulus: 20 consecutive issues with data = index.
  - Required: issue_ready stays 1; outputs are 0..19 in order; pointer wrap is exercised.
- Backpressure (DEPTH=4, latency 3):
  - Stimulus: toggle out_ready 1/0 every cycle while issuing whenever allowed.
  - Required: no loss, no duplicates; count + in_flight <= 4 on every cycle; overflow=0.
- Error:
  - Stimulus: res_valid=1 with in_flight=0, data 0x55.
  - Required: overflow=1 and stays set; count unchanged; 0x55 never appears on out_data.
